// File: rtl/sys_clkrst_gen.sv
// sys_clkrst_gen: clock/reset front end ahead of the sap SoC.
// Ring-counter clock divider (3 phases) plus lock-gated reset sequencer.
//
// Ports:
//   CLK125M        in   board clock, only clock in the block
//   io_systemReset in   synchronous active-high reset
//   i_pllLocked    in   PLL lock, asynchronous to CLK125M
//   o_systemClk    out  registered ring bit 0
//   o_systemClk2   out  registered ring bit PH2
//   o_systemClk3   out  registered ring bit PH3
//   o_phaseTick    out  one-cycle pulse on each o_systemClk rise
//   o_socReset     out  active-high SoC reset
//   o_ready        out  high while the sequencer is in RUN
module sys_clkrst_gen #(
    parameter int DIV      = 10,
    parameter int HIGH_CNT = 5,
    parameter int PH2      = 7,
    parameter int PH3      = 3,
    parameter int RST_HOLD = 64
) (
    input  logic CLK125M,
    input  logic io_systemReset,
    input  logic i_pllLocked,
    output logic o_systemClk,
    output logic o_systemClk2,
    output logic o_systemClk3,
    output logic o_phaseTick,
    output logic o_socReset,
    output logic o_ready
);

    localparam logic [DIV-1:0] INIT =
        {{(DIV-HIGH_CNT){1'b0}}, {HIGH_CNT{1'b1}}};
    localparam int CW = $clog2(RST_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RUN
    } state_t;

    logic [DIV-1:0] ring;
    logic           ring_ok;
    logic           lock_m;
    logic           lock_s;
    logic [CW-1:0]  hold_cnt;
    state_t         state;

    // Any population other than HIGH_CNT means the ring was upset.
    assign ring_ok = ($countones(ring) == HIGH_CNT);

    // Clock generation: free-running, untouched by lock state.
    always_ff @(posedge CLK125M) begin
        if (io_systemReset) begin
            ring         <= INIT;
            o_systemClk  <= 1'b0;
            o_systemClk2 <= 1'b0;
            o_systemClk3 <= 1'b0;
            o_phaseTick  <= 1'b0;
        end else begin
            if (ring_ok) begin
                ring <= {ring[DIV-2:0], ring[DIV-1]};
            end else begin
                ring <= INIT;
            end
            o_systemClk  <= ring[0];
            o_systemClk2 <= ring[PH2];
            o_systemClk3 <= ring[PH3];
            // Next o_systemClk is ring[0]; current one is the old value.
            o_phaseTick  <= ring[0] & ~o_systemClk;
        end
    end

    // Lock synchronizer and reset sequencer.
    always_ff @(posedge CLK125M) begin
        if (io_systemReset) begin
            lock_m     <= 1'b0;
            lock_s     <= 1'b0;
            hold_cnt   <= '0;
            state      <= WAIT_LOCK;
            o_socReset <= 1'b1;
            o_ready    <= 1'b0;
        end else begin
            lock_m <= i_pllLocked;
            lock_s <= lock_m;
            if (!ring_ok) begin
                hold_cnt   <= '0;
                state      <= WAIT_LOCK;
                o_socReset <= 1'b1;
                o_ready    <= 1'b0;
            end else begin
                unique case (state)
                    WAIT_LOCK: begin
                        hold_cnt   <= '0;
                        o_socReset <= 1'b1;
                        o_ready    <= 1'b0;
                        if (lock_s) begin
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!lock_s) begin
                            hold_cnt <= '0;
                            state    <= WAIT_LOCK;
                        end else if (o_phaseTick) begin
                            if (hold_cnt == CNT_LAST) begin
                                // Release lands one cycle after a
                                // rising edge of o_systemClk.
                                hold_cnt   <= '0;
                                state      <= RUN;
                                o_socReset <= 1'b0;
                                o_ready    <= 1'b1;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state      <= WAIT_LOCK;
                            o_socReset <= 1'b1;
                            o_ready    <= 1'b0;
                        end
                    end
                    default: begin
                        hold_cnt   <= '0;
                        state      <= WAIT_LOCK;
                        o_socReset <= 1'b1;
                        o_ready    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
